// File: rtl/cpu_multicycle.sv
// cpu_multicycle: parametrised multi-cycle execution core.
// Walks FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK per instruction, with an
// internal register file, carry/zero flags and a req/ready data-memory handshake.
module cpu_multicycle #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 8,
  localparam int unsigned RA_W  = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_instr_ready,
  input  logic              i_hold,
  input  logic [7:0]        i_opcode,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [RA_W-1:0]   i_address,
  output logic              o_wait,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_flags,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_retire,
  output logic              o_illegal
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback
  } state_e;

  localparam logic [3:0] OpNop = 4'd0;
  localparam logic [3:0] OpLdi = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpXor = 4'd6;
  localparam logic [3:0] OpMov = 4'd7;
  localparam logic [3:0] OpLd  = 4'd8;
  localparam logic [3:0] OpSt  = 4'd9;

  state_e state_q, state_d;

  // Latched instruction fields
  logic [3:0]        op_q;
  logic [DATA_W-1:0] data1_q;
  logic [DATA_W-1:0] data2_q;
  logic [RA_W-1:0]   rd_q;

  // Operands, result and architectural state
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic              res_c_q;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] data_q;
  logic              carry_q, zero_q;

  // Step enables derived by the FSM
  logic accept, decode_go, execute_go, mem_done, wb_go;

  // ALU outputs
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              flag_op;

  // Reserved opcode bits and data2 are carried but have no function.
  logic unused_bits;
  assign unused_bits = ^{i_opcode[7:4], data2_q};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state outputs
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    decode_go   = 1'b0;
    execute_go  = 1'b0;
    mem_done    = 1'b0;
    wb_go       = 1'b0;
    o_retire    = 1'b0;
    o_illegal   = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    unique case (state_q)
      StFetch: begin
        if (!i_hold && i_instr_ready) begin
          accept  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!i_hold) begin
          decode_go = 1'b1;
          state_d   = StExecute;
        end
      end
      StExecute: begin
        if (!i_hold) begin
          execute_go = 1'b1;
          if (op_q == OpNop) begin
            o_retire = 1'b1;
            state_d  = StFetch;
          end else if (op_q == OpLd || op_q == OpSt) begin
            state_d = StMem;
          end else if (op_q > OpSt) begin
            o_illegal = 1'b1;
            state_d   = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StMem: begin
        // Hold is ignored here so an outstanding request never drops.
        o_mem_req   = 1'b1;
        o_mem_we    = (op_q == OpSt);
        o_mem_addr  = data1_q;
        o_mem_wdata = a_q;
        if (i_mem_ready) begin
          mem_done = 1'b1;
          if (op_q == OpSt) begin
            o_retire = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        if (!i_hold) begin
          wb_go    = 1'b1;
          o_retire = 1'b1;
          state_d  = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  assign o_wait = (state_q != StFetch) | i_hold;

  // ALU: widened add/sub so the top bit is carry (add) or borrow (sub)
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OpLdi: alu_res = data1_q;
      OpAdd: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, data1_q};
      OpSub: {alu_c, alu_res} = {1'b0, a_q} - {1'b0, data1_q};
      OpAnd: alu_res = a_q & data1_q;
      OpOr:  alu_res = a_q | data1_q;
      OpXor: alu_res = a_q ^ data1_q;
      OpMov: alu_res = b_q;
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  assign flag_op = (op_q >= OpAdd) && (op_q <= OpXor);

  // Instruction latch, operand fetch, result capture and register writeback
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      res_c_q <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        op_q    <= i_opcode[3:0];
        data1_q <= i_data1;
        data2_q <= i_data2;
        rd_q    <= i_address;
      end
      if (decode_go) begin
        a_q <= rf_q[rd_q];
        b_q <= rf_q[data1_q[RA_W-1:0]];
      end
      if (execute_go) begin
        res_q   <= alu_res;
        res_c_q <= alu_c;
      end
      if (mem_done && op_q == OpLd) begin
        res_q <= i_mem_rdata;
      end
      if (wb_go) begin
        rf_q[rd_q] <= res_q;
        data_q     <= res_q;
        // Logic ops leave res_c_q at 0, which clears carry.
        if (flag_op) begin
          carry_q <= res_c_q;
          zero_q  <= (res_q == '0);
        end
      end
    end
  end

  assign o_data  = data_q;
  assign o_flags = {carry_q, zero_q};

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle, single-issue execution core that generalises the team's 8-bit fetch/decode/execute/memread/writeback CPU. It adds configurable datapath width and register count, an internal register file, an ALU with carry/zero flags, and a memory request handshake. It sits between the instruction feeder, which presents one instruction per handshake, and the data-memory port.

## Interface
- DATA_W, 8: datapath, immediate and memory-address width (≥4)
- NREGS, 8: register-file entries, power of two ≥2; RA_W = clog2(NREGS)
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset; synchronous and active-high
- i_instr_ready  in  1  instruction fields valid this cycle
- i_hold  in  1  stall request
- i_opcode  in  8  [3:0] op, [7:4] reserved and ignored
- i_data1  in  DATA_W  immediate, memory address, or source-register index (low RA_W bits)
- i_data2  in  DATA_W  reserved, latched and unused
- i_address  in  RA_W  destination/source register rd
- o_wait  out  1  core cannot accept an instruction this cycle
- o_data  out  DATA_W  last value written to the register file
- o_flags  out  2  {carry, zero}
- o_mem_req, o_mem_we  out  1  memory request, write enable
- o_mem_addr, o_mem_wdata  out  DATA_W  memory address, write data
- i_mem_ready  in  1  memory completes the request this cycle
- i_mem_rdata  in  DATA_W  read data, valid with i_mem_ready
- o_retire  out  1  one-cycle pulse when an instruction completes
- o_illegal  out  1  one-cycle pulse on an undefined op

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK. Reset enters FETCH.
- FETCH: if i_hold=0 and i_instr_ready=1, latch opcode, data1, data2 and address, then go to DECODE. Otherwise stay in FETCH.
- DECODE: register the operands: A = reg[rd], B = reg[data1[RA_W-1:0]]. Go to EXECUTE.
- EXECUTE: compute and register the result.
  - 0 NOP: go to FETCH with retire.
  - 1 LDI: res=data1.
  - 2 ADD: {c,res}=A+data1.
  - 3 SUB: res=A-data1, c=borrow.
  - 4 AND, 5 OR, 6 XOR: res = A op data1.
  - 7 MOV: res=B.
  - 8 LD, 9 ST: go to MEM.
  - 10-15: pulse o_illegal, go to FETCH, no state change and no retire.
  - All other ops go to WRITEBACK.
- MEM: hold o_mem_req=1, o_mem_addr=data1, o_mem_we=(op==ST), o_mem_wdata=A, all stable until i_mem_ready.
  - On ready, LD captures i_mem_rdata into res and goes to WRITEBACK.
  - On ready, ST retires and goes to FETCH.
- WRITEBACK: write reg[rd] and o_data with res, pulse o_retire, go to FETCH.
- Flags:
  - ADD, SUB, AND, OR and XOR update zero=(res==0). ADD and SUB also update carry; logic ops clear carry.
  - LDI, MOV and LD leave the flags unchanged.
- Arithmetic is modulo 2^DATA_W.
- i_hold freezes the current state in FETCH, DECODE, EXECUTE and WRITEBACK. It is ignored in MEM, so an outstanding request never drops.
- o_wait = (state!=FETCH) | i_hold. It is combinational.

## Timing
- Reset values:
  - State FETCH; all registers, o_data and o_flags are 0.
  - o_mem_req, o_mem_we, o_retire and o_illegal are 0.
  - o_mem_addr and o_mem_wdata are 0.
  - o_wait equals i_hold.
- Reset taken in any state, including MEM mid-request, deasserts o_mem_req on the next cycle and discards the instruction.
- Let the accept edge be cycle 0.
  - ALU/LDI/MOV: DECODE in cycle 1, EXECUTE in 2, WRITEBACK in 3 with o_retire high. o_data is updated at the end of cycle 3, and FETCH is back in cycle 4.
  - LD/ST: MEM starts in cycle 3 and lasts N+1 cycles when i_mem_ready arrives N cycles late.
    - LD retires N+1 cycles later than an ALU op.
    - ST retires in its last MEM cycle.
- A register written in WRITEBACK is visible to the next instruction's DECODE; no forwarding is needed.
- i_mem_ready outside MEM is ignored.
- i_instr_ready outside FETCH is ignored; the feeder must hold the fields until o_wait=0.

## Test plan
- Reset, then LDI r3,0x5A accepted at cycle 0 -> o_retire and o_data=0x5A in cycle 3; o_wait high in cycles 1-3 and low in cycle 4.
- LDI r1,0xF0; ADD r1,0x20 -> o_data=0x10, flags={1,0}. Then SUB r1,0x10 -> 0x00, flags={0,1}. Then SUB r1,0x01 -> 0xFF, carry=1.
- LD r2,[0x44] with i_mem_ready 3 cycles late -> o_mem_req held for 4 cycles at addr 0x44, we=0; rdata 0xC3 gives o_data=0xC3. Then ST r2,[0x45] -> we=1, wdata=0xC3, retire with no o_data change.
- i_hold=1 in FETCH with i_instr_ready=1 -> not accepted, o_wait=1. i_hold asserted for 2 cycles in DECODE -> retire delayed by exactly 2 cycles. i_hold in MEM -> request completes normally.
- Opcode 0x0F -> o_illegal pulse in cycle 2, no retire, registers and flags unchanged, FETCH in cycle 3. MOV r4,r3 afterwards -> o_data=reg[3].
- i_rst asserted during MEM -> o_mem_req=0 next cycle, all registers read 0 afterwards. Repeat the ADD-wrap case with DATA_W=16, NREGS=16: 0xFFF0+0x0020 -> 0x0010, carry=1.
